adc082s021_responder: RTL
=========================

Name: adc082s021_responder

Overview:
SPI responder that emulates one ADC082S021 dual-channel 8-bit ADC on the serial bus. It lets the existing ADC master driver be exercised in loopback and in board bring-up without the physical part. Runs entirely in the `clk` domain and oversamples sclk, mosi and ss. Each frame returns a sample from the channel addressed in the previous frame and captures the new address.

Parameters:
CPOL, 1'b0, sclk idle level; the leading edge is rising when CPOL=0.
SS, 1'b0, ss idle level; ss is active when it differs from SS.
DATA_W, 8, sample width.
FRAME_LEN, 16, sclk leading edges per frame.
SYNC_STAGES, 2, synchronizer flops on sclk, mosi and ss (minimum 2).

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
ch0_sample  in  DATA_W  channel 0 value
ch1_sample  in  DATA_W  channel 1 value
sclk  in  1  SPI clock from the master
mosi  in  1  SPI data from the master
ss  in  1  slave select from the master
miso  out  1  SPI data to the master
miso_oe  out  1  high while the frame is active
addr  out  3  address captured from the last complete frame
sample_ack  out  1  1-clk pulse when a sample is latched into the output shifter
sample_ch  out  1  channel of the latched sample, valid with sample_ack
frame_done  out  1  1-clk pulse when a complete frame ends
frame_err  out  1  1-clk pulse when a frame is aborted

Behaviour:
- Clock and reset: one clock, `clk`. Reset is synchronous and active-low on port `reset`; reset is asserted when reset==0 at a `clk` edge.
- Reset values: miso=0, miso_oe=0, addr=0, sample_ack=0, sample_ch=0, frame_done=0, frame_err=0, state=WAIT_IDLE, bit counter=0.
- Input conditioning:
  - sclk, mosi and ss pass through SYNC_STAGES flops.
  - Edge detection compares the last two synchronized sclk values.
  - Leading edge = transition away from CPOL; trailing edge = transition back to CPOL.
  - sclk high time and low time must each be ≥ SYNC_STAGES+2 clk periods. Faster sclk is unsupported.
- Frame format:
  - mosi bit order, MSB first: 2 don't-care, ADD2, ADD1, ADD0, 11 don't-care.
  - miso bits, MSB first: 4 zeros, sample[DATA_W-1:0], then FRAME_LEN-4-DATA_W zeros.
- State machine:
  - WAIT_IDLE → IDLE when synchronized ss is idle. WAIT_IDLE is entered after reset so the responder never joins a frame mid-way.
  - IDLE → ARMED on synchronized ss going active. In that same clk:
    - load the output shifter with the sample selected by addr[0];
    - miso_oe=1;
    - miso = first zero bit;
    - pulse sample_ack, with sample_ch=addr[0].
  - ARMED/SHIFT, on each leading edge:
    - shift synchronized mosi into the input shift register;
    - bit counter +1;
    - go to SHIFT.
  - SHIFT, on a trailing edge while bit counter < FRAME_LEN: advance miso to the next bit.
  - When the bit counter reaches FRAME_LEN:
    - next clk: addr ← bits [FRAME_LEN-3:FRAME_LEN-5] of the input register;
    - pulse frame_done;
    - go to DONE.
  - DONE: further sclk edges are ignored and miso holds 0. On ss going idle: miso_oe=0, counter=0, go to IDLE.
  - ARMED/SHIFT with ss going idle before FRAME_LEN edges: pulse frame_err, addr unchanged, miso=0, miso_oe=0, go to IDLE.
- Pipelining: the sample returned in frame N is selected by the address from frame N-1. After reset, the first frame returns ch0.
- Sample inputs are read only at the ARMED transition. Changes to them during a frame have no effect on that frame.
- Edge priority: an ss idle transition in the same clk as an sclk edge takes priority, and the edge is dropped.
- Reset mid-frame: outputs return to their reset values and the state is WAIT_IDLE. The responder re-arms only after ss has been seen idle.

Optional Feature:
- Macro ADC082S021_RESP_TESTPAT_EN.
- Defined:
  - ch0_sample and ch1_sample are ignored.
  - The sample is an internal DATA_W-bit counter, reset to 0, incremented after every sample_ack and wrapping at 2^DATA_W-1 → 0.
  - ch1 returns the bitwise inverse of the counter.
- Undefined: samples come from the input ports and no counter logic exists.

Decomposition:
- Package adc082s021_pkg holds:
  - FRAME_LEN default;
  - LEAD_ZEROS=4;
  - address bit positions;
  - the state enum: WAIT_IDLE, IDLE, ARMED, SHIFT, DONE.
- Sub-module spi_edge_sync contains the synchronizers plus leading/trailing/ss edge detection. It is reusable by other SPI responders.

Test Plan:
- Reset, then a frame with ADD=001 and ch0=8'hA5, ch1=8'h3C → miso returns 0000_1010_0101_0000; addr=3'b001; one frame_done pulse.
- Next frame with ADD=000 → miso returns 0000_0011_1100_0000 (ch1); addr=0.
- ss deasserted after 7 leading edges → frame_err pulses once; addr unchanged; the next frame samples the same channel.
- 20 sclk cycles in one ss window → frame_done after edge 16 only; miso is 0 for edges 17-20.
- Reset released while ss is active mid-frame → miso_oe stays 0 and no pulses occur until ss idles; the following frame is correct.
- With ADC082S021_RESP_TESTPAT_EN defined, 3 frames on ch0 → samples 8'h00, 8'h01, 8'h02; a frame on ch1 when the counter is 8'h03 → 8'hFC.

Source files
------------

// File: rtl/adc082s021_pkg.sv
// Shared constants and FSM state type for the ADC082S021 responder.
// Frame geometry, address bit offsets, responder states.
package adc082s021_pkg;

  localparam int FRAME_LEN_DEF = 16;
  localparam int LEAD_ZEROS    = 4;
  // ADD2..ADD0 land at [FRAME_LEN-3 : FRAME_LEN-5] after a frame
  localparam int ADDR_MSB_OFS  = 3;
  localparam int ADDR_LSB_OFS  = 5;

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    ARMED,
    SHIFT,
    DONE
  } state_t;

endpackage

// File: rtl/adc082s021_responder_if.sv
// SPI bus bundle between an ADC master and the responder.
// Ports: sclk, mosi, ss (master->slave), miso, miso_oe (slave->master).
interface adc082s021_responder_if;

  logic sclk;
  logic mosi;
  logic ss;
  logic miso;
  logic miso_oe;

  modport master (
    output sclk, mosi, ss,
    input  miso, miso_oe
  );

  modport slave (
    input  sclk, mosi, ss,
    output miso, miso_oe
  );

endinterface

// File: rtl/adc082s021_responder_spi_edge_sync.sv
// Synchronizes sclk/mosi/ss into clk and flags sclk and ss edges.
// Ports: clk, reset (sync, low), i_sclk/i_mosi/i_ss in; o_lead, o_trail, o_mosi, o_ss_act, o_ss_start, o_ss_end out.
module spi_edge_sync #(
  parameter logic CPOL        = 1'b0,
  parameter logic SS          = 1'b0,
  parameter int   SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_sclk,
  input  logic i_mosi,
  input  logic i_ss,
  output logic o_lead,
  output logic o_trail,
  output logic o_mosi,
  output logic o_ss_act,
  output logic o_ss_start,
  output logic o_ss_end
);

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [SYNC_STAGES-1:0] r_ss_sync;
  logic                   r_sclk_prev;
  logic                   r_ss_prev;
  logic                   w_sclk;
  logic                   w_ss;

  // ss chain resets to "active" so a frame already in flight at
  // reset release is never mistaken for an idle bus.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sclk_sync <= {SYNC_STAGES{CPOL}};
      r_mosi_sync <= '0;
      r_ss_sync   <= {SYNC_STAGES{~SS}};
      r_sclk_prev <= CPOL;
      r_ss_prev   <= ~SS;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], i_ss};
      r_sclk_prev <= w_sclk;
      r_ss_prev   <= w_ss;
    end
  end

  assign w_sclk     = r_sclk_sync[SYNC_STAGES-1];
  assign w_ss       = r_ss_sync[SYNC_STAGES-1];
  assign o_mosi     = r_mosi_sync[SYNC_STAGES-1];
  assign o_lead     = (r_sclk_prev == CPOL) && (w_sclk != CPOL);
  assign o_trail    = (r_sclk_prev != CPOL) && (w_sclk == CPOL);
  assign o_ss_act   = (w_ss != SS);
  assign o_ss_start = (r_ss_prev == SS) && (w_ss != SS);
  assign o_ss_end   = (r_ss_prev != SS) && (w_ss == SS);

endmodule

// File: rtl/adc082s021_responder.sv
// ADC082S021 SPI responder: returns a sample chosen by the previous frame's address.
// Ports: clk, reset (sync, low), ch0/ch1_sample, spi (slave), addr, sample_ack, sample_ch, frame_done, frame_err.
// Option: ADC082S021_RESP_TESTPAT_EN replaces the sample inputs with an internal counter.
module adc082s021_responder
  import adc082s021_pkg::*;
#(
  parameter logic CPOL        = 1'b0,
  parameter logic SS          = 1'b0,
  parameter int   DATA_W      = 8,
  parameter int   FRAME_LEN   = FRAME_LEN_DEF,
  parameter int   SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] ch0_sample,
  input  logic [DATA_W-1:0] ch1_sample,
  adc082s021_responder_if.slave spi,
  output logic [2:0]        addr,
  output logic              sample_ack,
  output logic              sample_ch,
  output logic              frame_done,
  output logic              frame_err
);

  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  localparam int TAIL  = FRAME_LEN - LEAD_ZEROS - DATA_W;
  // only the bits up to ADD2 are ever needed
  localparam int IN_W  = FRAME_LEN - ADDR_MSB_OFS + 1;

  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [IN_W-1:0]        r_in;
  logic [FRAME_LEN-1:0]   r_out;
  logic [DATA_W-1:0]      w_sample;
  logic [FRAME_LEN-1:0]   w_frame;
  logic                   w_lead;
  logic                   w_trail;
  logic                   w_mosi;
  logic                   w_ss_act;
  logic                   w_ss_start;
  logic                   w_ss_end;

  spi_edge_sync #(
    .CPOL        (CPOL),
    .SS          (SS),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk        (clk),
    .reset      (reset),
    .i_sclk     (spi.sclk),
    .i_mosi     (spi.mosi),
    .i_ss       (spi.ss),
    .o_lead     (w_lead),
    .o_trail    (w_trail),
    .o_mosi     (w_mosi),
    .o_ss_act   (w_ss_act),
    .o_ss_start (w_ss_start),
    .o_ss_end   (w_ss_end)
  );

`ifdef ADC082S021_RESP_TESTPAT_EN
  logic [DATA_W-1:0] r_tp;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_tp <= '0;
    end else if (sample_ack) begin
      r_tp <= r_tp + 1'b1;
    end
  end

  assign w_sample = addr[0] ? ~r_tp : r_tp;
`else
  assign w_sample = addr[0] ? ch1_sample : ch0_sample;
`endif

  assign w_frame = FRAME_LEN'(w_sample) << TAIL;

  // r_out holds the bits still to be sent; miso is its registered head
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= WAIT_IDLE;
      r_cnt       <= '0;
      r_in        <= '0;
      r_out       <= '0;
      spi.miso    <= 1'b0;
      spi.miso_oe <= 1'b0;
      addr        <= '0;
      sample_ack  <= 1'b0;
      sample_ch   <= 1'b0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      sample_ack <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      unique case (r_state)
        WAIT_IDLE: begin
          if (!w_ss_act) r_state <= IDLE;
        end
        IDLE: begin
          if (w_ss_start) begin
            r_out       <= w_frame << 1;
            spi.miso    <= w_frame[FRAME_LEN-1];
            spi.miso_oe <= 1'b1;
            sample_ack  <= 1'b1;
            sample_ch   <= addr[0];
            r_cnt       <= '0;
            r_state     <= ARMED;
          end
        end
        ARMED, SHIFT: begin
          if (r_cnt == CNT_W'(FRAME_LEN)) begin
            addr       <= r_in[IN_W-1:FRAME_LEN-ADDR_LSB_OFS];
            frame_done <= 1'b1;
            spi.miso   <= 1'b0;
            r_state    <= DONE;
          end else if (w_ss_end) begin
            // ss drop wins over a coincident sclk edge
            frame_err   <= 1'b1;
            spi.miso    <= 1'b0;
            spi.miso_oe <= 1'b0;
            r_cnt       <= '0;
            r_state     <= IDLE;
          end else if (w_lead) begin
            r_in    <= {r_in[IN_W-2:0], w_mosi};
            r_cnt   <= r_cnt + 1'b1;
            r_state <= SHIFT;
          end else if (w_trail && (r_state == SHIFT)) begin
            spi.miso <= r_out[FRAME_LEN-1];
            r_out    <= r_out << 1;
          end
        end
        DONE: begin
          if (!w_ss_act) begin
            spi.miso_oe <= 1'b0;
            r_cnt       <= '0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= WAIT_IDLE;
      endcase
    end
  end

endmodule
